fetch_stage0: RTL and testbench

- Stage 0 (instruction fetch) of the pipelined BPF controller.
- Owns the program counter and drives the synchronous instruction memory.
- Presents the current instruction (opcode, jt, jf, k) to the stage-1 decode/compute1 block.
- Honours the stage-1 stall, takes redirects from stage 2 (resolved jumps) and stops on RET/halt from stage 2.

---
 rtl/fetch_stage0_if.sv | 36 +++
 rtl/fetch_stage0.sv | 105 ++++++++++
 tb/tb_fetch_stage0.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage0_if.sv
// Bundle between the fetch stage, instruction memory and the stage-1/stage-2 control.
// The master modport is the fetch stage.
interface fetch_stage0_if #(
  parameter int PC_WIDTH  = 10,
  parameter int CNT_WIDTH = 32
);
  logic                 start;
  logic                 stage1_stalled;
  logic                 branch_taken;
  logic [PC_WIDTH-1:0]  branch_target;
  logic                 halt;
  logic [PC_WIDTH-1:0]  inst_mem_addr;
  logic                 inst_mem_rd_en;
  logic [63:0]          inst_mem_data;
  logic [15:0]          opcode;
  logic [7:0]           jt;
  logic [7:0]           jf;
  logic [31:0]          imm;
  logic [PC_WIDTH-1:0]  insn_pc;
  logic                 insn_valid;
  logic                 done;
  logic                 error;
  logic [CNT_WIDTH-1:0] insn_count;

  modport master (
    input  start, stage1_stalled, branch_taken, branch_target, halt, inst_mem_data,
    output inst_mem_addr, inst_mem_rd_en, opcode, jt, jf, imm, insn_pc,
           insn_valid, done, error, insn_count
  );

  modport slave (
    output start, stage1_stalled, branch_taken, branch_target, halt, inst_mem_data,
    input  inst_mem_addr, inst_mem_rd_en, opcode, jt, jf, imm, insn_pc,
           insn_valid, done, error, insn_count
  );
endinterface

// File: rtl/fetch_stage0.sv
// Stage 0 of the BPF pipeline: owns the PC, drives the synchronous instruction
// memory and presents the fetched instruction to stage 1.
module fetch_stage0 #(
  parameter int PC_WIDTH  = 10,
  parameter int CNT_WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst,
  fetch_stage0_if.master bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  localparam logic [PC_WIDTH-1:0]  PC_LAST = '1;
  localparam logic [PC_WIDTH-1:0]  PC_ONE  = {{(PC_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_e               state_q, state_d;
  logic [PC_WIDTH-1:0]  pc_q, pc_d;
  logic [PC_WIDTH-1:0]  next_pc;
  logic                 error_q, error_d;
  logic                 done_q, done_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 rd_en;
  logic                 valid;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    error_d = error_q;
    count_d = count_q;
    next_pc = pc_q;
    rd_en   = 1'b0;
    valid   = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        rd_en = bus.start;
        // IDLE always points memory at 0; DONE keeps the halted PC unless restarting
        if (state_q == IDLE || bus.start) begin
          next_pc = '0;
        end
        if (bus.start) begin
          state_d = RUN;
          pc_d    = '0;
          error_d = 1'b0;
          count_d = '0;
        end
      end
      RUN: begin
        rd_en = 1'b1;
        valid = !bus.branch_taken && !bus.halt;
        if (valid && !bus.stage1_stalled && count_q != CNT_MAX) begin
          count_d = count_q + CNT_ONE;
        end
        if (bus.halt) begin
          state_d = DONE;
        end else if (bus.branch_taken) begin
          next_pc = bus.branch_target;
        end else if (bus.stage1_stalled) begin
          next_pc = pc_q;
        end else if (pc_q == PC_LAST) begin
          // Falling off the end of the program is an error, never a wrap to 0
          state_d = DONE;
          error_d = 1'b1;
        end else begin
          next_pc = pc_q + PC_ONE;
        end
        pc_d = next_pc;
      end
      default: state_d = IDLE;
    endcase
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      pc_q    <= '0;
      error_q <= 1'b0;
      done_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      error_q <= error_d;
      done_q  <= done_d;
      count_q <= count_d;
    end
  end

  // Read enable is forced low while reset is asserted, even if start is high
  assign bus.inst_mem_rd_en = rd_en && rst;
  assign bus.inst_mem_addr  = next_pc;
  assign bus.opcode         = bus.inst_mem_data[63:48];
  assign bus.jt             = bus.inst_mem_data[47:40];
  assign bus.jf             = bus.inst_mem_data[39:32];
  assign bus.imm            = bus.inst_mem_data[31:0];
  assign bus.insn_pc        = pc_q;
  assign bus.insn_valid     = valid;
  assign bus.done           = done_q;
  assign bus.error          = error_q;
  assign bus.insn_count     = count_q;

endmodule

// File: tb/tb_fetch_stage0.sv
// Self-checking bench for fetch_stage0: directed scenarios plus random control
// traffic checked each cycle against a behavioural model of the fetch rules.
module tb_fetch_stage0;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  fetch_stage0_if #(.PC_WIDTH(10), .CNT_WIDTH(32)) bus ();
  fetch_stage0_if #(.PC_WIDTH(4),  .CNT_WIDTH(32)) sbus ();

  fetch_stage0 #(.PC_WIDTH(10), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .bus(bus.master)
  );

  fetch_stage0 #(.PC_WIDTH(4), .CNT_WIDTH(32)) dut_small (
    .clk(clk), .rst(rst), .bus(sbus.master)
  );

  logic [63:0] mem  [1024];
  logic [63:0] smem [16];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous instruction memories: data appears one cycle after the address
  always @(posedge clk) begin
    if (bus.inst_mem_rd_en) bus.inst_mem_data <= mem[bus.inst_mem_addr];
    if (sbus.inst_mem_rd_en) sbus.inst_mem_data <= smem[sbus.inst_mem_addr];
  end

  // Behavioural model: 0 = idle, 1 = running, 2 = done
  int          m_state;
  int unsigned m_pc;
  int unsigned m_cnt;
  bit          m_err;

  task automatic compare(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input bit s, input bit st, input bit br,
                             input int unsigned tgt, input bit h);
    int unsigned exp_addr;
    bit          exp_rd;
    bit          exp_valid;
    exp_addr  = 0;
    exp_rd    = s;
    exp_valid = 0;
    if (m_state == 2 && !s) exp_addr = m_pc;
    if (m_state == 1) begin
      exp_rd    = 1;
      exp_valid = !br && !h;
      if (h || (!br && st) || (!br && m_pc == 1023)) exp_addr = m_pc;
      else if (br) exp_addr = tgt;
      else exp_addr = m_pc + 1;
      compare("insn_data", {bus.opcode, bus.jt, bus.jf, bus.imm}, mem[m_pc]);
    end
    compare("inst_mem_addr", bus.inst_mem_addr, exp_addr);
    compare("inst_mem_rd_en", bus.inst_mem_rd_en, exp_rd);
    compare("insn_valid", bus.insn_valid, exp_valid);
    compare("insn_pc", bus.insn_pc, m_pc);
    compare("done", bus.done, m_state == 2);
    compare("error", bus.error, m_err);
    compare("insn_count", bus.insn_count, m_cnt);
  endtask

  // One clock cycle: drive inputs, check mid-cycle, then advance the model
  task automatic applyStimulus(input bit s, input bit st, input bit br,
                               input int unsigned tgt, input bit h);
    bus.start          = s;
    bus.stage1_stalled = st;
    bus.branch_taken   = br;
    bus.branch_target  = tgt[9:0];
    bus.halt           = h;
    @(negedge clk);
    checkOutput(s, st, br, tgt, h);
    if (m_state != 1) begin
      if (s) begin
        m_state = 1;
        m_pc    = 0;
        m_err   = 0;
        m_cnt   = 0;
      end
    end else begin
      if (!br && !h && !st && m_cnt != 32'hFFFF_FFFF) m_cnt++;
      if (h) m_state = 2;
      else if (br) m_pc = tgt;
      else if (st) m_pc = m_pc;
      else if (m_pc == 1023) begin
        m_state = 2;
        m_err   = 1;
      end else m_pc++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int unsigned tgt;
    rst = 1'b0;
    m_state = 0; m_pc = 0; m_cnt = 0; m_err = 0;
    bus.start = 0; bus.stage1_stalled = 0; bus.branch_taken = 0;
    bus.branch_target = '0; bus.halt = 0;
    sbus.start = 0; sbus.stage1_stalled = 0; sbus.branch_taken = 0;
    sbus.branch_target = '0; sbus.halt = 0;
    for (int i = 0; i < 1024; i++) mem[i] = {$urandom, $urandom};
    for (int i = 0; i < 16; i++) smem[i] = {$urandom, $urandom};

    #2;
    checkOutput(0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Straight-line fetch of 0..3
    applyStimulus(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 0);
    compare("count_after_4", bus.insn_count, 4);
    applyStimulus(0, 0, 0, 0, 1);

    // Restart, then stall three cycles at PC 2
    applyStimulus(1, 0, 0, 0, 0);
    compare("restart_count", bus.insn_count, 0);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 0, 0);
    compare("stall_count", bus.insn_count, 2);
    applyStimulus(0, 0, 0, 0, 0);
    compare("pc_after_stall", bus.insn_pc, 3);

    // Branch to 0x20 at PC 5 together with a stall: branch wins
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 1, 1, 32'h20, 0);
    compare("branch_pc", bus.insn_pc, 10'h20);
    compare("branch_data", {bus.opcode, bus.jt, bus.jf, bus.imm}, mem[32]);

    // Reach PC 7 and halt there, then restart
    applyStimulus(0, 0, 1, 6, 0);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1);
    compare("halt_done", bus.done, 1);
    compare("halt_rd_en", bus.inst_mem_rd_en, 0);
    compare("halt_valid", bus.insn_valid, 0);
    applyStimulus(1, 0, 0, 0, 0);
    compare("restart_pc", bus.insn_pc, 0);
    compare("restart_done", bus.done, 0);
    compare("restart_cnt", bus.insn_count, 0);

    // Asynchronous reset mid-run at PC 9
    for (int i = 0; i < 20 && m_pc != 9; i++) applyStimulus(0, 0, 0, 0, 0);
    compare("reach_pc9", bus.insn_pc, 9);
    #3 rst = 1'b0;
    #1;
    compare("areset_rd_en", bus.inst_mem_rd_en, 0);
    compare("areset_addr", bus.inst_mem_addr, 0);
    compare("areset_valid", bus.insn_valid, 0);
    compare("areset_pc", bus.insn_pc, 0);
    compare("areset_done", bus.done, 0);
    compare("areset_error", bus.error, 0);
    compare("areset_count", bus.insn_count, 0);
    m_state = 0; m_pc = 0; m_cnt = 0; m_err = 0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(0, 0, 0, 0, 0);

    // Random control traffic, with targets biased toward the top of memory
    for (int i = 0; i < 400; i++) begin
      tgt = ($urandom_range(3) == 0) ? 1020 + $urandom_range(3) : $urandom_range(1023);
      applyStimulus($urandom_range(2) == 0, $urandom_range(3) == 0,
                    $urandom_range(9) == 0, tgt, $urandom_range(24) == 0);
    end
    applyStimulus(0, 0, 0, 0, 0);

    // 4-bit PC instance: run off the end without wrapping to address 0
    sbus.start = 1;
    @(negedge clk);
    compare("small_start_addr", sbus.inst_mem_addr, 0);
    compare("small_start_rd", sbus.inst_mem_rd_en, 1);
    @(posedge clk);
    #1;
    sbus.start = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      compare("small_pc", sbus.insn_pc, i);
      compare("small_valid", sbus.insn_valid, 1);
      compare("small_addr", sbus.inst_mem_addr, (i == 15) ? 15 : i + 1);
      compare("small_data", {sbus.opcode, sbus.jt, sbus.jf, sbus.imm}, smem[i]);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    compare("small_done", sbus.done, 1);
    compare("small_error", sbus.error, 1);
    compare("small_rd_en", sbus.inst_mem_rd_en, 0);
    compare("small_valid_end", sbus.insn_valid, 0);
    compare("small_count", sbus.insn_count, 16);
    compare("small_pc_held", sbus.insn_pc, 15);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
